m_if_queue: RTL

//  Instruction fetch stage with prefetch queue, directly upstream of the ID stage (register file read).

---
 rtl/m_if_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/m_if_queue.sv
// Instruction fetch stage with a prefetch queue feeding the ID stage.
// Fetch drives r_pc into an asynchronous instruction memory and captures
// {pc, ir} pairs into a small FIFO; ID drains the FIFO over valid/ready.
// A redirect from EX flushes the queue and restarts fetch at a new PC.
module m_if_queue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst_n,
  output logic [31:0]                w_imem_addr,
  input  logic [31:0]                w_imem_data,
  input  logic                       w_redirect,
  input  logic [31:0]                w_redirect_pc,
  output logic                       w_id_valid,
  input  logic                       w_id_ready,
  output logic [31:0]                w_id_ir,
  output logic [31:0]                w_id_pc,
  output logic [$clog2(DEPTH):0]     w_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // architectural state
  logic [31:0]   r_pc;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // queue storage (not reset; only entries below count are ever observed)
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];

  // next-state signals
  logic          not_empty;
  logic          pop;
  logic          push;
  logic [31:0]   pc_d;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr_d;

  // low PC bits of the redirect target are dropped on load
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^w_redirect_pc[1:0];

  assign not_empty = (count_q != '0);

  // handshake qualification and next-state computation; redirect wins over everything
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    pc_d     = r_pc;
    count_d  = count_q;
    rd_ptr_d = rd_ptr;
    wr_ptr_d = wr_ptr;

    if (w_redirect) begin
      pc_d     = {w_redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      pop  = not_empty & w_id_ready;
      // a full queue may still accept a fetch when the head leaves on the same edge
      push = (count_q < FULL_COUNT) | pop;

      if (push) begin
        pc_d     = r_pc + 32'd4;
        wr_ptr_d = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // state register with asynchronous active-low reset
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pc    <= RESET_PC;
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      r_pc    <= pc_d;
      count_q <= count_d;
      rd_ptr  <= rd_ptr_d;
      wr_ptr  <= wr_ptr_d;
    end
  end

  // capture the fetched {pc, ir} pair into the tail entry
  always_ff @(posedge w_clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= r_pc;
      ir_mem[wr_ptr] <= w_imem_data;
    end
  end

  // head of queue presented to ID; zeros while empty
  always_comb begin
    w_id_valid = not_empty & ~w_redirect;
    w_id_ir    = '0;
    w_id_pc    = '0;
    if (not_empty) begin
      w_id_ir = ir_mem[rd_ptr];
      w_id_pc = pc_mem[rd_ptr];
    end
  end

  assign w_imem_addr = r_pc;
  assign w_count     = count_q;

endmodule
